// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver with mid-bit sampling, sticky error flags and a FWFT byte FIFO.
module uart_rx_buffered #(
  parameter int CLOCK_FREQ  = 50_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int BUFFER_SIZE = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx,
  output logic [7:0]                   rd_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [$clog2(BUFFER_SIZE):0] rx_count,
  output logic                         frame_error,
  output logic                         overflow,
  input  logic                         clear_errors
);
  localparam int CPB = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(BUFFER_SIZE);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic [AW:0]   FULL = (AW + 1)'(BUFFER_SIZE);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           rx_meta_q, rx_s_q;
  logic           push, fe_set, pop, full, push_ok;
  logic [7:0]     mem_q [BUFFER_SIZE];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q, count_d;
  logic           fe_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
    end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    push    = 1'b0;
    fe_set  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: if (cnt_q == LAST) begin
        cnt_d   = '0;
        shift_d = {rx_s_q, shift_q[7:1]};
        idx_d   = idx_q + 1'b1;
        if (idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (cnt_q == LAST) begin
        cnt_d   = '0;
        push    = rx_s_q;
        fe_set  = !rx_s_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // a full FIFO still accepts a byte when the head is popped in the same cycle
  assign rd_valid = count_q != '0;
  assign full     = count_q == FULL;
  assign pop      = rd_valid & rd_ready;
  assign push_ok  = push & (!full | pop);
  assign count_d  = (push_ok && !pop) ? count_q + 1'b1 : (!push_ok && pop) ? count_q - 1'b1 : count_q;
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign rx_count    = count_q;
  assign frame_error = fe_q;
  assign overflow    = ovf_q;

  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fe_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_q  <= count_d;
      fe_q     <= fe_set | (fe_q & ~clear_errors);
      ovf_q    <= (push & full & !pop) | (ovf_q & ~clear_errors);
    end
endmodule
